// File: rtl/calc_self_test.sv
// Self-test engine for the 4-bit signed calculator: sweeps every {KEY,SW}
// vector, decodes the seven-segment response and scores it against a golden model.
//
// state  | meaning
// IDLE   | waiting for start, outputs parked at zero
// DRIVE  | register vector v onto calc_key/calc_sw
// SETTLE | hold the vector while the calculator output settles
// CHECK  | sample HEX digits, score pass/fail
// NEXT   | advance v or finish the sweep
// DONE   | sweep finished, results held until the next start
module calc_self_test #(
    parameter int SETTLE_CYCLES = 4,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        start,
    output logic [2:0]  calc_key,
    output logic [7:0]  calc_sw,
    input  logic [6:0]  dut_hex3,
    input  logic [6:0]  dut_hex2,
    input  logic [6:0]  dut_hex0,
    output logic        busy,
    output logic        done,
    output logic [11:0] pass_cnt,
    output logic [11:0] fail_cnt,
    output logic        fail_valid,
    output logic [10:0] fail_vec
);

    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [10:0]     v;
    logic [TW-1:0]   timer;
    logic signed [5:0] a, b, r, mag;
    logic            ovf, match;
    logic [6:0]      exp_sign, exp_mag;

    function automatic logic [6:0] seg_digit(input logic [5:0] d);
        case (d)
            6'd0:    return 7'b1000000;
            6'd1:    return 7'b1111001;
            6'd2:    return 7'b0100100;
            6'd3:    return 7'b0110000;
            6'd4:    return 7'b0011001;
            6'd5:    return 7'b0010010;
            6'd6:    return 7'b0000010;
            6'd7:    return 7'b1111000;
            6'd8:    return 7'b0000000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Golden model evaluated on the vector currently driven onto the calculator
    assign a = {{2{calc_sw[7]}}, calc_sw[7:4]};
    assign b = {{2{calc_sw[3]}}, calc_sw[3:0]};

    always_comb begin
        r = '0;
        case (calc_key[1:0])
            2'b00:   r = calc_key[2] ? (b + a) : (a + b);
            2'b01:   r = calc_key[2] ? (b - a) : (a - b);
            default: begin
                if (calc_key[2]) r = (a < 0) ? -a : a;
                else             r = (b < 0) ? -b : b;
            end
        endcase
    end

    assign ovf      = (r > 6'sd7) || (r < -6'sd8);
    assign mag      = (r < 0) ? -r : r;
    assign exp_sign = (r < 0) ? SEG_DASH : SEG_BLANK;
    assign exp_mag  = seg_digit(mag);
    assign match    = ovf ? (dut_hex0 == SEG_E)
                          : ({dut_hex3, dut_hex2, dut_hex0} == {exp_sign, exp_mag, SEG_BLANK});

    assign busy = (state == S_DRIVE) || (state == S_SETTLE) ||
                  (state == S_CHECK) || (state == S_NEXT);
    assign done = (state == S_DONE);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_DRIVE;
            S_DRIVE:  state_nx = S_SETTLE;
            S_SETTLE: if (timer == '0) state_nx = S_CHECK;
            S_CHECK:  state_nx = (!match && STOP_ON_FAIL) ? S_DONE : S_NEXT;
            S_NEXT:   state_nx = (v == 11'd2047) ? S_DONE : S_DRIVE;
            S_DONE:   if (start) state_nx = S_DRIVE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            v          <= '0;
            timer      <= '0;
            calc_key   <= '0;
            calc_sw    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        v          <= '0;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                S_DRIVE: begin
                    calc_key <= v[10:8];
                    calc_sw  <= v[7:0];
                    timer    <= TW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: if (timer != '0) timer <= timer - TW'(1);
                S_CHECK: begin
                    if (match) begin
                        pass_cnt <= pass_cnt + 12'd1;
                    end else begin
                        fail_cnt <= fail_cnt + 12'd1;
                        if (!fail_valid) begin
                            fail_vec   <= v;
                            fail_valid <= 1'b1;
                        end
                    end
                end
                S_NEXT: if (v != 11'd2047) v <= v + 11'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/calc_self_test.md
Name: calc_self_test

Overview:
- On-board stimulus and checker engine for the 4-bit signed calculator.
- It drives the calculator's operation and operand inputs (KEY[2:0], SW[7:0]) through all 2048 combinations.
- For each combination it waits a settle interval, decodes the calculator's seven-segment outputs (HEX3, HEX2, HEX0) and compares them against an internal golden model.
- Pass and fail counts and the first failing vector are reported; the block sits beside the calculator on the board and replaces manual switch testing.

Parameters:
SETTLE_CYCLES, 4, clock cycles held per vector before sampling (>=1)
STOP_ON_FAIL, 0, 1 = stop at the first mismatch, 0 = run the full sweep

Ports:
CLOCK_50  input  1  system clock
RESET_N  input  1  synchronous active-low reset
start  input  1  one-cycle pulse starting a sweep
calc_key  output  3  drives calculator KEY[2:0]
calc_sw  output  8  drives calculator SW[7:0]; A=[7:4], B=[3:0], both two's complement
dut_hex3  input  7  calculator sign digit, active-low, bit order gfedcba
dut_hex2  input  7  calculator magnitude digit
dut_hex0  input  7  calculator overflow digit
busy  output  1  sweep in progress
done  output  1  sweep finished, sticky
pass_cnt  output  12  vectors that matched
fail_cnt  output  12  vectors that mismatched
fail_valid  output  1  fail_vec holds a captured vector
fail_vec  output  11  {KEY,SW} of the first mismatch

Behaviour:
- Reset (RESET_N=0 at a clock edge, including mid-sweep):
  - state=IDLE.
  - All outputs 0, except calc_key=0 and calc_sw=0.
  - Vector index v cleared.
- Vector mapping: 11-bit index v; calc_key=v[10:8], calc_sw=v[7:0]. v runs 0..2047 in ascending order.
- States:
  - IDLE: on start, go to DRIVE, clear counters, fail_valid and v.
  - DRIVE: register calc_key/calc_sw from v (1 cycle), then SETTLE.
  - SETTLE: hold outputs for SETTLE_CYCLES cycles, then CHECK.
  - CHECK (1 cycle):
    - Sample the HEX inputs and compare; increment pass_cnt or fail_cnt.
    - On the first fail, capture fail_vec=v and set fail_valid=1.
    - If the vector failed and STOP_ON_FAIL=1, go to DONE; otherwise go to NEXT.
  - NEXT: if v==2047 go to DONE; otherwise v<=v+1 and go to DRIVE.
  - DONE: done=1, busy=0; calc_key/calc_sw hold the last vector. start here restarts exactly as from IDLE.
- busy=1 in DRIVE, SETTLE, CHECK and NEXT.
- start is ignored while busy.
- Cycles per vector = SETTLE_CYCLES+3. A full sweep takes 2048*(SETTLE_CYCLES+3) cycles.
- Golden model (A, B sign-extended to 5 bits):
  - KEY[1:0]=00, add: R=A+B if KEY[2]=0, otherwise B+A.
  - KEY[1:0]=01, subtract: R=A-B if KEY[2]=0, otherwise B-A.
  - KEY[1:0]=1x, absolute value: R=|B| if KEY[2]=0, otherwise |A|.
  - Overflow when R>7 or R<-8; abs(-8) overflows.
- Glyphs (active-low gfedcba):
  - Digits 0..8: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000.
  - '-'=0111111, blank=1111111, 'E'=0000110.
- Expected display:
  - Overflow: HEX0='E'; HEX3 and HEX2 are don't-care.
  - No overflow:
    - HEX0=blank.
    - HEX3='-' if R<0, else blank.
    - HEX2=digit(|R|). Zero shows blank sign and '0'.
- Counters are 12-bit and never saturate in one sweep (maximum 2048).
- The comparison uses only values sampled in CHECK. Inputs are assumed stable after the settle interval, and the block does not re-synchronise them.

Test Plan:
1. Correct calculator model, SETTLE_CYCLES=4, pulse start -> done rises 14336 cycles after DRIVE entry; pass_cnt=2048, fail_cnt=0, fail_valid=0.
2. dut_hex0 stuck at blank -> fail_cnt=320 (128 add + 128 subtract + 64 abs overflow vectors); pass_cnt=1728; fail_vec=11'h017 (KEY=000, A=1, B=7).
3. Same fault with STOP_ON_FAIL=1 -> DONE after vector 0x017; pass_cnt=23, fail_cnt=1, fail_valid=1.
4. Assert RESET_N low at vector 500, then pulse start -> all counters 0 after reset; the new sweep begins at v=0 and completes with 2048 passes.
5. Pulse start twice while busy -> counters unaffected, single sweep. Pulse start in DONE -> counters clear and a second full sweep completes.
6. Model with subtraction swapped (A-B vs B-A) -> first fail_vec=11'h101 (KEY=001, A=0, B=1); no fails for vectors with KEY[1:0]!=01.
